// File: rtl/cordic_pkg.sv
// Shared constants and FSM state type for the cordic job scheduler.
// Angle format: 1 LSB = 1/128 degree, signed 16-bit.
package cordic_pkg;

    localparam int ANG_W = 16;
    localparam logic [ANG_W-1:0] ANG_180  = 16'h5A00;
    localparam logic [ANG_W-1:0] ANG_N180 = 16'hA600;
    localparam int SMP_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from ptr, wrapping.
// Zero latency; no grant while en is low.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Shares one cordic engine among NREQ requesters; grant -> result in 4..14 cycles, abandon after TIMEOUT.
// Requesters wait on req_ready; grants only while idle with the engine ready and done.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 31
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*SMP_W-1:0] req_x,
    input  logic [NREQ*SMP_W-1:0] req_y,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic [ANG_W-1:0]      res_angle,
    output logic                  res_err,
    output logic                  eng_start,
    output logic [SMP_W-1:0]      eng_x,
    output logic [SMP_W-1:0]      eng_y,
    input  logic [ANG_W-1:0]      eng_angle,
    input  logic                  eng_done,
    input  logic                  eng_ready
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  cur_id;
    logic [TW-1:0]   timer;

    logic            arb_en;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  nxt_ptr;
    logic [SMP_W-1:0] sel_x;
    logic [SMP_W-1:0] sel_y;

    // resetn gates the grant so req_ready stays low through reset
    assign arb_en = resetn && (state == IDLE) && eng_ready && eng_done;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign nxt_ptr   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign sel_x     = req_x[int'(gnt_idx)*SMP_W +: SMP_W];
    assign sel_y     = req_y[int'(gnt_idx)*SMP_W +: SMP_W];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            timer     <= '0;
            eng_start <= 1'b0;
            eng_x     <= '0;
            eng_y     <= '0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            res_id    <= '0;
            res_angle <= '0;
        end else begin
            eng_start <= 1'b0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        eng_x     <= sel_x;
                        eng_y     <= sel_y;
                        cur_id    <= gnt_idx;
                        rr_ptr    <= nxt_ptr;
                        eng_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        res_valid <= 1'b1;
                        res_angle <= eng_angle;
                        res_id    <= cur_id;
                        state     <= IDLE;
                    end else if (timer == TW'(TIMEOUT)) begin
                        res_err <= 1'b1;
                        res_id  <= cur_id;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench for cordic_sched with a behavioural engine of programmable latency.
module tb_cordic_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_x;
    logic [NREQ*8-1:0] req_y;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [15:0]       res_angle;
    logic              res_err;
    logic              eng_start;
    logic [7:0]        eng_x;
    logic [7:0]        eng_y;
    logic [15:0]       eng_angle;
    logic              eng_done;
    logic              eng_ready;

    cordic_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(31)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_angle (res_angle),
        .res_err   (res_err),
        .eng_start (eng_start),
        .eng_x     (eng_x),
        .eng_y     (eng_y),
        .eng_angle (eng_angle),
        .eng_done  (eng_done),
        .eng_ready (eng_ready)
    );

    always #5 clk = ~clk;

    // Engine model: done drops on start, rises lat cycles after the first WAIT cycle
    int   lat;
    logic hang;
    int   cnt;

    function automatic logic [15:0] model_ang(input logic signed [7:0] x, input logic signed [7:0] y);
        if (y == 0 && x > 0) return 16'h0000;
        if (x == y && x > 0) return 16'h1680;
        if (x == -y && x < 0) return 16'h4380;
        return {x, y};
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            eng_done  <= 1'b1;
            eng_angle <= '0;
            cnt       <= 0;
        end else if (eng_start) begin
            eng_done <= 1'b0;
            cnt      <= lat;
        end else if (!eng_done && !hang) begin
            if (cnt <= 1) begin
                eng_done  <= 1'b1;
                eng_angle <= model_ang(eng_x, eng_y);
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    int multi_cnt = 0;
    int start_cnt = 0;
    int rv_cnt    = 0;
    int rdy_cnt [NREQ];

    initial for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;

    always @(negedge clk) begin
        if ($countones(req_ready) > 1) multi_cnt++;
        if (eng_start) start_cnt++;
        if (res_valid) rv_cnt++;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) rdy_cnt[i]++;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [NREQ-1:0] s_rdy;
    logic            s_rv, s_err, s_start;
    logic [IDW-1:0]  s_id;
    logic [15:0]     s_ang;
    logic [7:0]      s_ex, s_ey;
    int              s_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_rdy   = req_ready;
        s_rv    = res_valid;
        s_err   = res_err;
        s_start = eng_start;
        s_id    = res_id;
        s_ang   = res_angle;
        s_ex    = eng_x;
        s_ey    = eng_y;
        s_cyc   = cyc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y);
        req_x[i*8 +: 8] = x;
        req_y[i*8 +: 8] = y;
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic run_job(input string tag, input int id, input logic [7:0] x, input logic [7:0] y,
                           input int l, output int latc, output logic [31:0] rid,
                           output logic [31:0] rang, output logic isv, output logic iserr);
        int g;
        g = -1;
        latc = -1; rid = '1; rang = '1; isv = 1'b0; iserr = 1'b0;
        lat = l;
        set_req(id, x, y);
        req_valid[id] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (s_rdy != 0) begin
                g = s_cyc;
                break;
            end
        end
        req_valid[id] = 1'b0;
        chk({tag, "_grant"}, s_rdy, 32'(1 << id));
        for (int k = 0; k < 60 && g >= 0; k++) begin
            tick();
            if (s_rv || s_err) begin
                latc  = s_cyc - g;
                rid   = 32'(s_id);
                rang  = 32'(s_ang);
                isv   = s_rv;
                iserr = s_err;
                break;
            end
        end
    endtask

    int          latc;
    logic [31:0] rid, rang;
    logic        isv, iserr;
    int          base, base2, grants, ndone, gi;
    int          n_job [NREQ];
    int          q_id[$];
    logic [15:0] q_ang[$];
    int          order[$];

    initial begin
        resetn    = 1'b0;
        req_valid = 4'b1111;
        req_x     = '0;
        req_y     = '0;
        eng_ready = 1'b1;
        lat       = 1;
        hang      = 1'b0;
        tick();
        tick();
        chk("rst_ready", s_rdy, 0);
        chk("rst_outs", {s_rv, s_err, s_start, s_id, s_ang, s_ex, s_ey}, 0);
        req_valid = '0;
        resetn    = 1'b1;
        tick();

        // Single request, y = 0 early exit
        base = rdy_cnt[2];
        run_job("r2", 2, 8'd10, 8'd0, 1, latc, rid, rang, isv, iserr);
        tick();
        chk("r2_lat", latc, 4);
        chk("r2_id", rid, 2);
        chk("r2_ang", rang, 16'h0000);
        chk("r2_valid", {isv, iserr}, 2'b10);
        chk("r2_ready_pulses", rdy_cnt[2] - base, 1);

        run_job("r0_45", 0, 8'd64, 8'd64, 5, latc, rid, rang, isv, iserr);
        tick();
        chk("r0_45_lat", latc, 8);
        chk("r0_45_id", rid, 0);
        chk("r0_45_ang", rang, 16'h1680);

        // -64 / 64 -> 135 degrees, worst-case engine latency
        run_job("r1_135", 1, 8'hC0, 8'd64, 11, latc, rid, rang, isv, iserr);
        tick();
        chk("r1_135_lat", latc, 14);
        chk("r1_135_id", rid, 1);
        chk("r1_135_ang", rang, 16'h4380);

        // Engine never completes
        hang = 1'b1;
        base = rv_cnt;
        run_job("to", 3, 8'd5, 8'd7, 1, latc, rid, rang, isv, iserr);
        chk("to_lat", latc, 34);
        chk("to_err", {isv, iserr}, 2'b01);
        chk("to_id", rid, 3);
        chk("to_no_valid", rv_cnt - base, 0);
        hang = 1'b0;
        run_job("after_to", 0, 8'd10, 8'd0, 1, latc, rid, rang, isv, iserr);
        tick();
        chk("after_to_lat", latc, 4);
        chk("after_to_id", rid, 0);

        // Reset during WAIT drops the job
        lat = 11;
        set_req(2, 8'd1, 8'd2);
        req_valid[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (s_rdy != 0) break;
        end
        req_valid[2] = 1'b0;
        chk("mid_grant", s_rdy, 4'b0100);
        tick();
        tick();
        chk("mid_in_wait_x", s_ex, 8'd1);
        resetn = 1'b0;
        tick();
        tick();
        chk("mid_rst_outs", {s_rdy, s_rv, s_err, s_start, s_id, s_ang, s_ex, s_ey}, 0);
        resetn = 1'b1;
        base = rv_cnt;
        for (int k = 0; k < 20; k++) tick();
        chk("mid_no_result", rv_cnt - base, 0);
        run_job("post_rst", 3, 8'd10, 8'd0, 1, latc, rid, rang, isv, iserr);
        tick();
        chk("post_rst_lat", latc, 4);
        chk("post_rst_id", rid, 3);

        // All four continuously valid for 12 jobs
        lat = 1;
        for (int i = 0; i < NREQ; i++) begin
            n_job[i] = 0;
            set_req(i, 8'(i * 16), 8'(8'h70 + i));
        end
        base  = start_cnt;
        base2 = multi_cnt;
        grants = 0;
        ndone  = 0;
        req_valid = 4'b1111;
        for (int k = 0; k < 400 && ndone < 12; k++) begin
            tick();
            if (s_rv) begin
                if (q_id.size() > 0) begin
                    chk("rr_res_id", s_id, q_id.pop_front());
                    chk("rr_res_ang", s_ang, q_ang.pop_front());
                end
                ndone++;
            end
            if (s_rdy != 0) begin
                gi = onehot_idx(s_rdy);
                chk("rr_order", gi, grants % NREQ);
                q_id.push_back(gi);
                q_ang.push_back({8'(gi * 16 + n_job[gi]), 8'(8'h70 + gi)});
                grants++;
                n_job[gi]++;
                if (grants == 12) req_valid = '0;
                else set_req(gi, 8'(gi * 16 + n_job[gi]), 8'(8'h70 + gi));
            end
        end
        chk("rr_done", ndone, 12);
        chk("rr_starts", start_cnt - base, 12);
        chk("rr_multi_ready", multi_cnt - base2, 0);

        // Requester 1 withdraws before its turn
        base = rdy_cnt[1];
        set_req(0, 8'd3, 8'd4);
        set_req(1, 8'd5, 8'd6);
        set_req(3, 8'd7, 8'd9);
        req_valid = 4'b1011;
        for (int k = 0; k < 300 && order.size() < 4; k++) begin
            tick();
            if (s_rdy != 0) begin
                order.push_back(onehot_idx(s_rdy));
                req_valid[1] = 1'b0;
            end
        end
        req_valid = '0;
        for (int k = 0; k < 20; k++) tick();
        chk("drop_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) chk("drop_order", order[i], (i % 2 == 0) ? 0 : 3);
        chk("drop_r1_never", rdy_cnt[1] - base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
